fetch_pc_btb: RTL and testbench

Fetch-stage program-counter unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. Each cycle it supplies the fetch PC and a predicted next PC (PPC); the PPC travels down the pipeline to Execute. It consumes the resolved next PC from Execute, detects mispredictions, flushes the younger stages, redirects fetch, and trains the BTB.

---
 rtl/fetch_pc_btb_pkg.sv | 22 ++
 rtl/fetch_pc_btb_array.sv | 34 +++
 rtl/fetch_pc_btb.sv | 107 ++++++++++
 tb/tb_fetch_pc_btb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_btb_pkg.sv
// Shared types for the fetch PC unit and its branch target buffer.
package fetch_pc_btb_pkg;

   localparam int P_WIDTH = 32;
   localparam logic [P_WIDTH-1:0] P_RESET_PC = '0;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Tag held zero-extended so one struct serves any index width.
   typedef struct packed {
      logic               valid;
      logic [P_WIDTH-1:0] tag;
      logic [P_WIDTH-1:0] target;
      ctr_t               ctr;
   } btb_entry_t;

endpackage

// File: rtl/fetch_pc_btb_array.sv
// Direct-mapped BTB storage: two combinational reads, one write, sync clear.
module fetch_pc_btb_array
   import fetch_pc_btb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX     = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX-1:0]   fetch_idx,
   output btb_entry_t       fetch_entry,
   input  logic [IDX-1:0]   ex_idx,
   output btb_entry_t       ex_entry,
   input  logic             wr_en,
   input  logic [IDX-1:0]   wr_idx,
   input  btb_entry_t       wr_data
);

   btb_entry_t mem [ENTRIES];

   assign fetch_entry = mem[fetch_idx];
   assign ex_entry    = mem[ex_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/fetch_pc_btb.sv
// Fetch PC register with BTB prediction, mispredict redirect and training.
module fetch_pc_btb
   import fetch_pc_btb_pkg::*;
#(
   parameter int                WIDTH       = P_WIDTH,
   parameter int                BTB_ENTRIES = 16,
   parameter logic [WIDTH-1:0]  RESET_PC    = P_RESET_PC
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_Stall,
   output logic [WIDTH-1:0] o_PC,
   output logic [WIDTH-1:0] o_PPC,
   output logic             o_Flush,
   input  logic             i_EX_Valid,
   input  logic [WIDTH-1:0] i_EX_PC,
   input  logic [WIDTH-1:0] i_EX_PPC,
   input  logic [WIDTH-1:0] i_EX_New_PC,
   input  logic [WIDTH-1:0] i_EX_Target,
   input  logic             i_EX_Taken,
   input  logic             i_EX_Branch,
   input  logic             i_EX_Jump
);

   localparam int IDX = $clog2(BTB_ENTRIES);

   logic [IDX-1:0]     f_idx;
   logic [IDX-1:0]     e_idx;
   logic [P_WIDTH-1:0] f_tag;
   logic [P_WIDTH-1:0] e_tag;
   btb_entry_t         f_ent;
   btb_entry_t         e_ent;
   logic               f_hit;
   logic               e_hit;
   logic               mispredict;
   logic               wr_en;
   btb_entry_t         wr_data;

   assign f_idx = IDX'(o_PC >> 2);
   assign e_idx = IDX'(i_EX_PC >> 2);
   assign f_tag = P_WIDTH'(o_PC >> (IDX + 2));
   assign e_tag = P_WIDTH'(i_EX_PC >> (IDX + 2));

   fetch_pc_btb_array #(
      .ENTRIES (BTB_ENTRIES),
      .IDX     (IDX)
   ) u_btb (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .fetch_idx   (f_idx),
      .fetch_entry (f_ent),
      .ex_idx      (e_idx),
      .ex_entry    (e_ent),
      .wr_en       (wr_en),
      .wr_idx      (e_idx),
      .wr_data     (wr_data)
   );

   assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
   assign e_hit = e_ent.valid && (e_ent.tag == e_tag);

   assign o_PPC = (f_hit && (f_ent.ctr >= WT)) ?
                  WIDTH'(f_ent.target) : o_PC + WIDTH'(4);

   assign mispredict = i_EX_Valid && (i_EX_PPC != i_EX_New_PC);
   assign o_Flush    = mispredict;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_PC <= RESET_PC;
      end else if (mispredict) begin
         o_PC <= i_EX_New_PC;
      end else if (!i_Stall) begin
         o_PC <= o_PPC;
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_data = e_ent;
      if (i_EX_Valid) begin
         if (i_EX_Branch || i_EX_Jump) begin
            if (e_hit) begin
               wr_en = 1'b1;
               if (i_EX_Taken) begin
                  wr_data.target = P_WIDTH'(i_EX_Target);
                  if (e_ent.ctr != ST)
                     wr_data.ctr = ctr_t'(e_ent.ctr + 2'd1);
               end else if (e_ent.ctr != SNT) begin
                  wr_data.ctr = ctr_t'(e_ent.ctr - 2'd1);
               end
            end else if (i_EX_Taken) begin
               wr_en   = 1'b1;
               wr_data = '{valid:  1'b1,
                           tag:    e_tag,
                           target: P_WIDTH'(i_EX_Target),
                           ctr:    WT};
            end
         end else if (e_hit) begin
            // Stale entry aliased onto a non-branch: drop it.
            wr_en         = 1'b1;
            wr_data.valid = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Bench for fetch_pc_btb: directed table plus randomized model comparison.
module tb_fetch_pc_btb;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_Stall;
   logic [31:0] o_PC;
   logic [31:0] o_PPC;
   logic        o_Flush;
   logic        i_EX_Valid;
   logic [31:0] i_EX_PC;
   logic [31:0] i_EX_PPC;
   logic [31:0] i_EX_New_PC;
   logic [31:0] i_EX_Target;
   logic        i_EX_Taken;
   logic        i_EX_Branch;
   logic        i_EX_Jump;

   always #5 i_clk = ~i_clk;

   fetch_pc_btb dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_Stall     (i_Stall),
      .o_PC        (o_PC),
      .o_PPC       (o_PPC),
      .o_Flush     (o_Flush),
      .i_EX_Valid  (i_EX_Valid),
      .i_EX_PC     (i_EX_PC),
      .i_EX_PPC    (i_EX_PPC),
      .i_EX_New_PC (i_EX_New_PC),
      .i_EX_Target (i_EX_Target),
      .i_EX_Taken  (i_EX_Taken),
      .i_EX_Branch (i_EX_Branch),
      .i_EX_Jump   (i_EX_Jump)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a 16-entry table of rule-level state.
   bit          m_known = 0;
   logic [31:0] m_pc;
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> 6));
   endfunction

   function automatic logic [31:0] m_ppc(logic [31:0] pc);
      if (m_hit(pc) && m_ctr[idx_of(pc)] >= 2) return m_tgt[idx_of(pc)];
      return pc + 32'd4;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(bit rst, bit stall, bit v, logic [31:0] epc,
                       logic [31:0] eppc, logic [31:0] enew,
                       logic [31:0] etgt, bit tk, bit br, bit jp,
                       bit tab, logic [31:0] t_pc, logic [31:0] t_ppc,
                       bit t_fl);
      logic [31:0] e_ppc;
      bit          e_fl;
      int          k;
      i_rst_n     = !rst;
      i_Stall     = stall;
      i_EX_Valid  = v;
      i_EX_PC     = epc;
      i_EX_PPC    = eppc;
      i_EX_New_PC = enew;
      i_EX_Target = etgt;
      i_EX_Taken  = tk;
      i_EX_Branch = br;
      i_EX_Jump   = jp;
      #1;
      e_fl = v && (eppc != enew);
      check("flush_model", {31'd0, o_Flush}, {31'd0, e_fl});
      if (m_known) begin
         e_ppc = m_ppc(m_pc);
         check("pc_model", o_PC, m_pc);
         check("ppc_model", o_PPC, e_ppc);
      end else begin
         e_ppc = '0;
      end
      if (tab) begin
         check("pc_table", o_PC, t_pc);
         check("ppc_table", o_PPC, t_ppc);
         check("flush_table", {31'd0, o_Flush}, {31'd0, t_fl});
      end
      @(posedge i_clk);
      if (rst) begin
         m_known = 1;
         m_pc = 32'h0;
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
         end
      end else begin
         k = idx_of(epc);
         if (v && (br || jp)) begin
            if (m_hit(epc)) begin
               if (tk) begin
                  m_tgt[k] = etgt;
                  if (m_ctr[k] < 3) m_ctr[k]++;
               end else if (m_ctr[k] > 0) begin
                  m_ctr[k]--;
               end
            end else if (tk) begin
               m_valid[k] = 1;
               m_tag[k]   = epc >> 6;
               m_tgt[k]   = etgt;
               m_ctr[k]   = 2;
            end
         end else if (v && m_hit(epc)) begin
            m_valid[k] = 0;
         end
         if (e_fl) m_pc = enew;
         else if (!stall) m_pc = e_ppc;
      end
      #1;
   endtask

   typedef struct {
      bit          stall;
      bit          v;
      logic [31:0] epc;
      logic [31:0] eppc;
      logic [31:0] enew;
      logic [31:0] etgt;
      bit          tk;
      bit          br;
      bit          jp;
      logic [31:0] x_pc;
      logic [31:0] x_ppc;
      bit          x_fl;
   } vec_t;

   vec_t tbl [26];

   initial begin
      logic [31:0] rpc, rtgt, rnew, rppc;
      int          kind;
      bit          rtk;

      // st v  epc    eppc   enew   tgt    tk br jp  pc     ppc    fl
      tbl[0]  = '{0,0,0,0,0,0,0,0,0, 32'h0, 32'h4, 0};
      tbl[1]  = '{0,0,0,0,0,0,0,0,0, 32'h4, 32'h8, 0};
      tbl[2]  = '{0,0,0,0,0,0,0,0,0, 32'h8, 32'hC, 0};
      tbl[3]  = '{0,1,32'h10,32'h14,32'h40,32'h40,1,1,0, 32'hC, 32'h10, 1};
      tbl[4]  = '{0,0,0,0,0,0,0,0,0, 32'h40, 32'h44, 0};
      tbl[5]  = '{0,1,32'h44,32'h48,32'h10,0,0,0,0, 32'h44, 32'h48, 1};
      tbl[6]  = '{1,0,0,0,0,0,0,0,0, 32'h10, 32'h40, 0};
      tbl[7]  = '{1,1,32'h10,32'h40,32'h14,32'h40,0,1,0, 32'h10, 32'h40, 1};
      tbl[8]  = '{0,1,32'h20,32'h24,32'h10,0,0,0,0, 32'h14, 32'h18, 1};
      tbl[9]  = '{1,0,0,0,0,0,0,0,0, 32'h10, 32'h14, 0};
      tbl[10] = '{1,1,32'h10,32'h14,32'h40,32'h40,1,1,0, 32'h10, 32'h14, 1};
      tbl[11] = '{0,1,32'h10,32'h40,32'h40,32'h40,1,1,0, 32'h40, 32'h44, 0};
      tbl[12] = '{0,1,32'h10,32'h40,32'h40,32'h40,1,1,0, 32'h44, 32'h48, 0};
      tbl[13] = '{0,1,32'h10,32'h40,32'h14,32'h40,0,1,0, 32'h48, 32'h4C, 1};
      tbl[14] = '{0,1,32'h20,32'h24,32'h10,0,0,0,0, 32'h14, 32'h18, 1};
      tbl[15] = '{1,0,0,0,0,0,0,0,0, 32'h10, 32'h40, 0};
      tbl[16] = '{1,1,32'h50,32'h40,32'h54,0,0,0,0, 32'h10, 32'h40, 1};
      tbl[17] = '{0,1,32'h20,32'h24,32'h10,0,0,0,0, 32'h54, 32'h58, 1};
      tbl[18] = '{1,0,0,0,0,0,0,0,0, 32'h10, 32'h40, 0};
      tbl[19] = '{1,1,32'h10,32'h40,32'h14,0,0,0,0, 32'h10, 32'h40, 1};
      tbl[20] = '{0,1,32'h20,32'h24,32'h10,0,0,0,0, 32'h14, 32'h18, 1};
      tbl[21] = '{1,0,32'h10,32'h99,32'h200,32'h300,1,1,0,
                  32'h10, 32'h14, 0};
      tbl[22] = '{1,0,0,0,0,0,0,0,0, 32'h10, 32'h14, 0};
      tbl[23] = '{0,1,32'h20,32'h24,32'hFFFF_FFFC,0,0,0,0,
                  32'h10, 32'h14, 1};
      tbl[24] = '{0,0,0,0,0,0,0,0,0, 32'hFFFF_FFFC, 32'h0, 0};
      tbl[25] = '{0,0,0,0,0,0,0,0,0, 32'h0, 32'h4, 0};

      @(posedge i_clk);
      #1;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      foreach (tbl[i]) begin
         step(0, tbl[i].stall, tbl[i].v, tbl[i].epc, tbl[i].eppc,
              tbl[i].enew, tbl[i].etgt, tbl[i].tk, tbl[i].br,
              tbl[i].jp, 1, tbl[i].x_pc, tbl[i].x_ppc, tbl[i].x_fl);
      end

      // Reset while a taken branch and a redirect are pending.
      step(0, 0, 1, 32'h80, 32'h84, 32'h200, 32'h200, 1, 1, 0,
           0, 0, 0, 0);
      step(1, 0, 1, 32'h80, 32'h84, 32'h200, 32'h200, 1, 1, 0,
           0, 0, 0, 1);
      step(0, 0, 1, 32'h80, 32'h200, 32'h200, 32'h200, 1, 1, 0,
           1, 32'h0, 32'h4, 0);

      for (int n = 0; n < 600; n++) begin
         rpc  = 32'($urandom_range(0, 63)) << 2;
         rtgt = 32'($urandom_range(0, 255)) << 2;
         kind = $urandom_range(0, 3);
         rtk  = (kind == 3) ? 1'b1 :
                (kind == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         rnew = rtk ? rtgt : rpc + 32'd4;
         rppc = ($urandom_range(0, 1) == 1) ? rnew :
                32'($urandom_range(0, 255)) << 2;
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0),
              rpc, rppc, rnew, rtgt, rtk,
              (kind == 1) || (kind == 2), (kind == 3),
              0, 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
